// File: rtl/data_packager_param.sv
// Symbol <-> word packager: the pack path gathers SYM_W-bit symbols into WORD_W-bit FIFO words with TLAST/flush, and the unpack path splits words back into symbols.
// Optional packet counter on port pkt_count, enabled by defining PACKAGER_STATS_EN.
module data_packager_param #(
    parameter int WORD_W    = 32,
    parameter int SYM_W     = 1,
    parameter int PKT_WORDS = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              out_fifo_valid,
    output logic [WORD_W-1:0] out_fifo_data,
    input  logic              out_fifo_ready,
    output logic              out_fifo_last,
    input  logic              in_fifo_valid,
    input  logic [WORD_W-1:0] in_fifo_data,
    output logic              in_fifo_ready,
    output logic              out_valid,
    output logic [SYM_W-1:0]  out_data,
    input  logic              out_ready,
    input  logic              in_valid,
    input  logic [SYM_W-1:0]  in_data,
    output logic              in_ready,
    input  logic              flush
`ifdef PACKAGER_STATS_EN
    ,
    output logic [CNT_W-1:0]  pkt_count
`endif
);

    localparam int SPW    = WORD_W / SYM_W;
    localparam int SIDX_W = (SPW > 1) ? $clog2(SPW) : 1;
    localparam int WIDX_W = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam logic [SIDX_W-1:0] SIDX_LAST = SIDX_W'(SPW - 1);
    localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(PKT_WORDS - 1);

    if (WORD_W % SYM_W != 0 || PKT_WORDS < 1 || CNT_W < 1) begin : g_cfg_err
        $error("data_packager_param: invalid parameter combination");
    end

    // Pack path state
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [SIDX_W-1:0] sidx_q, sidx_d;
    logic [WIDX_W-1:0] widx_q, widx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              word_valid_q, word_valid_d;
    logic              word_last_q, word_last_d;
    logic              flush_pend_q, flush_pend_d;
    logic              word_hs, out_free;

    // Unpack path state
    logic [WORD_W-1:0] hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic [SIDX_W-1:0] uidx_q, uidx_d;

    assign out_free       = !word_valid_q || out_fifo_ready;
    assign word_hs        = word_valid_q && out_fifo_ready;
    assign in_ready       = !flush_pend_q && out_free;
    assign out_fifo_valid = word_valid_q;
    assign out_fifo_data  = word_q;
    assign out_fifo_last  = word_last_q;

    assign out_valid     = hold_valid_q;
    assign out_data      = hold_q[uidx_q*SYM_W +: SYM_W];
    assign in_fifo_ready = !hold_valid_q || (out_ready && uidx_q == SIDX_LAST);

    always_comb begin
        // NOTE: every next-state value gets a default first, so no path can infer a latch.
        acc_d        = acc_q;
        sidx_d       = sidx_q;
        widx_d       = widx_q;
        word_d       = word_q;
        word_valid_d = word_valid_q;
        word_last_d  = word_last_q;
        flush_pend_d = flush_pend_q;

        if (word_hs) begin
            word_valid_d = 1'b0;
            widx_d       = (word_last_q || widx_q == WIDX_LAST) ? '0 : widx_q + 1'b1;
        end

        // A new word's last flag uses the index after this cycle's word handshake.
        if (in_valid && in_ready) begin
            acc_d[sidx_q*SYM_W +: SYM_W] = in_data;
            if (sidx_q == SIDX_LAST) begin
                word_d       = acc_d;
                word_valid_d = 1'b1;
                word_last_d  = (widx_d == WIDX_LAST);
                acc_d        = '0;
                sidx_d       = '0;
            end else begin
                sidx_d = sidx_q + 1'b1;
            end
        end else if (flush_pend_q && out_free) begin
            flush_pend_d = 1'b0;
            widx_d       = '0;
            if (sidx_q != '0) begin
                word_d       = acc_q;
                word_valid_d = 1'b1;
                word_last_d  = 1'b1;
                acc_d        = '0;
                sidx_d       = '0;
            end
        end

        if (flush) begin
            flush_pend_d = 1'b1;
        end
    end

    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        uidx_d       = uidx_q;

        if (hold_valid_q && out_ready) begin
            if (uidx_q == SIDX_LAST) begin
                uidx_d       = '0;
                hold_valid_d = 1'b0;
            end else begin
                uidx_d = uidx_q + 1'b1;
            end
        end

        if (in_fifo_valid && in_fifo_ready) begin
            hold_d       = in_fifo_data;
            hold_valid_d = 1'b1;
            uidx_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            acc_q        <= '0;
            sidx_q       <= '0;
            widx_q       <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            word_last_q  <= 1'b0;
            flush_pend_q <= 1'b0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            uidx_q       <= '0;
        end else begin
            acc_q        <= acc_d;
            sidx_q       <= sidx_d;
            widx_q       <= widx_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            word_last_q  <= word_last_d;
            flush_pend_q <= flush_pend_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            uidx_q       <= uidx_d;
        end
    end

`ifdef PACKAGER_STATS_EN
    logic [CNT_W-1:0] pkt_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_q <= '0;
        end else if (word_hs && word_last_q) begin
            pkt_count_q <= pkt_count_q + 1'b1;
        end
    end

    assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_data_packager_param.sv
// Directed bench for data_packager_param with WORD_W=32, SYM_W=2, PKT_WORDS=4.
// pkt_count checks are compiled in only when PACKAGER_STATS_EN is defined.
module tb_data_packager_param;

    localparam int WORD_W    = 32;
    localparam int SYM_W     = 2;
    localparam int PKT_WORDS = 4;
    localparam int CNT_W     = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              out_fifo_valid;
    logic [WORD_W-1:0] out_fifo_data;
    logic              out_fifo_ready = 1'b0;
    logic              out_fifo_last;
    logic              in_fifo_valid = 1'b0;
    logic [WORD_W-1:0] in_fifo_data = '0;
    logic              in_fifo_ready;
    logic              out_valid;
    logic [SYM_W-1:0]  out_data;
    logic              out_ready = 1'b0;
    logic              in_valid = 1'b0;
    logic [SYM_W-1:0]  in_data = '0;
    logic              in_ready;
    logic              flush = 1'b0;
`ifdef PACKAGER_STATS_EN
    logic [CNT_W-1:0]  pkt_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    data_packager_param #(
        .WORD_W(WORD_W), .SYM_W(SYM_W), .PKT_WORDS(PKT_WORDS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .out_fifo_valid(out_fifo_valid), .out_fifo_data(out_fifo_data),
        .out_fifo_ready(out_fifo_ready), .out_fifo_last(out_fifo_last),
        .in_fifo_valid(in_fifo_valid), .in_fifo_data(in_fifo_data),
        .in_fifo_ready(in_fifo_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .flush(flush)
`ifdef PACKAGER_STATS_EN
        , .pkt_count(pkt_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_fifo_ready = 1'b0;
        in_fifo_valid = 1'b0; in_fifo_data = '0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({out_fifo_valid, out_fifo_last, out_valid} !== 3'b000) $display("FAIL reset_valids: got %b expected 000", {out_fifo_valid, out_fifo_last, out_valid});
        else n_pass++;
        n_checks++;
        if (out_fifo_data !== 32'h0 || out_data !== 2'd0) $display("FAIL reset_data: got %h/%h expected 0/0", out_fifo_data, out_data);
        else n_pass++;
        n_checks++;
        if ({in_ready, in_fifo_ready} !== 2'b11) $display("FAIL reset_ready: got %b expected 11", {in_ready, in_fifo_ready});
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_pack_word();
        apply_reset();
        out_fifo_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1;
            in_data  = 2'(i % 4);
            step();
        end
        n_checks++;
        if (out_fifo_valid !== 1'b0) $display("FAIL pack_early_valid: got %b expected 0", out_fifo_valid);
        else n_pass++;
        in_data = 2'd3;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_fifo_valid !== 1'b1 || out_fifo_data !== 32'hE4E4E4E4 || out_fifo_last !== 1'b0)
            $display("FAIL pack_word: got v=%b d=%h l=%b expected v=1 d=e4e4e4e4 l=0", out_fifo_valid, out_fifo_data, out_fifo_last);
        else n_pass++;
        step();
        n_checks++;
        if (out_fifo_valid !== 1'b0) $display("FAIL pack_word_drain: got %b expected 0", out_fifo_valid);
        else n_pass++;
    endtask

    task automatic test_stream();
        logic [WORD_W-1:0] wdata [4];
        logic              wlast [4];
        int                words = 0;
        int                drops = 0;
        apply_reset();
        out_fifo_ready = 1'b1;
        for (int i = 0; i < 65; i++) begin
            in_valid = (i < 64);
            in_data  = 2'(i % 4);
            if (i < 64 && in_ready !== 1'b1) drops++;
            step();
            if (out_fifo_valid === 1'b1) begin
                if (words < 4) begin
                    wdata[words] = out_fifo_data;
                    wlast[words] = out_fifo_last;
                end
                words++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (words !== 4) $display("FAIL stream_words: got %0d expected 4", words);
        else n_pass++;
        n_checks++;
        if (drops !== 0) $display("FAIL stream_in_ready: in_ready low %0d cycles, expected 0", drops);
        else n_pass++;
        for (int k = 0; k < 4 && k < words; k++) begin
            n_checks++;
            if (wdata[k] !== 32'hE4E4E4E4 || wlast[k] !== (k == 3))
                $display("FAIL stream_word%0d: got d=%h l=%b expected d=e4e4e4e4 l=%0d", k, wdata[k], wlast[k], (k == 3));
            else n_pass++;
        end
`ifdef PACKAGER_STATS_EN
        n_checks++;
        if (pkt_count !== 16'd1) $display("FAIL stats_count: got %0d expected 1", pkt_count);
        else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (pkt_count !== 16'd0) $display("FAIL stats_reset: got %0d expected 0", pkt_count);
        else n_pass++;
`endif
    endtask

    task automatic test_backpressure();
        int bad = 0;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 2'(i % 4);
            step();
        end
        in_data = 2'd1;
        for (int c = 0; c < 5; c++) begin
            if (in_ready !== 1'b0 || out_fifo_valid !== 1'b1 || out_fifo_data !== 32'hE4E4E4E4 || out_fifo_last !== 1'b0) bad++;
            step();
        end
        n_checks++;
        if (bad !== 0) $display("FAIL bp_hold: %0d unstable cycles, expected 0", bad);
        else n_pass++;
        out_fifo_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", in_ready);
        else n_pass++;
        step();
        n_checks++;
        if (out_fifo_valid !== 1'b0) $display("FAIL bp_transfer: got %b expected 0", out_fifo_valid);
        else n_pass++;
        for (int k = 1; k < 16; k++) begin
            in_data = 2'((k + 1) % 4);
            step();
        end
        in_valid = 1'b0;
        n_checks++;
        if (out_fifo_valid !== 1'b1 || out_fifo_data !== 32'h39393939 || out_fifo_last !== 1'b0)
            $display("FAIL bp_next_word: got v=%b d=%h l=%b expected v=1 d=39393939 l=0", out_fifo_valid, out_fifo_data, out_fifo_last);
        else n_pass++;
        step();
    endtask

    task automatic test_flush();
        apply_reset();
        out_fifo_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 2'(i);
            step();
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL flush_pending_ready: got %b expected 0", in_ready);
        else n_pass++;
        step();
        n_checks++;
        if (out_fifo_valid !== 1'b1 || out_fifo_data !== 32'h00000039 || out_fifo_last !== 1'b1)
            $display("FAIL flush_word: got v=%b d=%h l=%b expected v=1 d=00000039 l=1", out_fifo_valid, out_fifo_data, out_fifo_last);
        else n_pass++;
        step();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 2'(i % 4);
            step();
        end
        in_valid = 1'b0;
        n_checks++;
        if (out_fifo_valid !== 1'b1 || out_fifo_data !== 32'hE4E4E4E4 || out_fifo_last !== 1'b0)
            $display("FAIL flush_restart: got v=%b d=%h l=%b expected v=1 d=e4e4e4e4 l=0", out_fifo_valid, out_fifo_data, out_fifo_last);
        else n_pass++;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        step();
        n_checks++;
        if (out_fifo_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_empty: got v=%b rdy=%b expected v=0 rdy=1", out_fifo_valid, in_ready);
        else n_pass++;
    endtask

    task automatic run_unpack(input bit toggle);
        int       wi = 0;
        int       ei = 0;
        int       gaps = 0;
        bit       started = 1'b0;
        bit       hs_word, hs_sym;
        logic [1:0] exp_sym;
        apply_reset();
        in_fifo_valid = 1'b1;
        in_fifo_data  = 32'hE4E4E4E4;
        for (int cyc = 0; cyc < 200 && ei < 32; cyc++) begin
            out_ready = toggle ? (cyc % 3 != 1) : 1'b1;
            #1;
            hs_word = in_fifo_valid && in_fifo_ready;
            hs_sym  = out_valid && out_ready;
            if (started && !out_valid) gaps++;
            if (out_valid) started = 1'b1;
            if (hs_sym) begin
                exp_sym = (ei < 16) ? 2'(ei % 4) : ((ei < 18) ? 2'd3 : 2'd0);
                n_checks++;
                if (out_data !== exp_sym) $display("FAIL unpack_sym%0d (toggle=%0d): got %0d expected %0d", ei, toggle, out_data, exp_sym);
                else n_pass++;
                ei++;
            end
            step();
            if (hs_word) begin
                wi++;
                in_fifo_valid = (wi < 2);
                in_fifo_data  = (wi == 1) ? 32'h0000000F : 32'h0;
            end
        end
        out_ready = 1'b1;
        n_checks++;
        if (ei !== 32 || out_valid !== 1'b0)
            $display("FAIL unpack_count (toggle=%0d): got %0d symbols, out_valid=%b, expected 32 and 0", toggle, ei, out_valid);
        else n_pass++;
        if (!toggle) begin
            n_checks++;
            if (gaps !== 0) $display("FAIL unpack_bubble: got %0d gap cycles expected 0", gaps);
            else n_pass++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_unpack();
        run_unpack(1'b0);
        run_unpack(1'b1);
    endtask

    task automatic test_mid_reset();
        int extra = 0;
        apply_reset();
        out_fifo_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 2'(i % 4);
            step();
        end
        in_valid      = 1'b0;
        in_fifo_valid = 1'b1;
        in_fifo_data  = 32'hE4E4E4E4;
        step();
        in_fifo_valid = 1'b0;
        out_ready     = 1'b1;
        repeat (5) step();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 2'd1) $display("FAIL midrst_pre: got v=%b d=%0d expected v=1 d=1", out_valid, out_data);
        else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({out_valid, out_fifo_valid, out_fifo_last} !== 3'b000 || out_data !== 2'd0 || out_fifo_data !== 32'h0)
            $display("FAIL midrst_clear: got v=%b fv=%b l=%b d=%0d fd=%h expected all 0", out_valid, out_fifo_valid, out_fifo_last, out_data, out_fifo_data);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 0) ? 2'd3 : 2'd0;
            step();
        end
        in_valid = 1'b0;
        n_checks++;
        if (out_fifo_valid !== 1'b1 || out_fifo_data !== 32'h00000003)
            $display("FAIL midrst_word: got v=%b d=%h expected v=1 d=00000003", out_fifo_valid, out_fifo_data);
        else n_pass++;
        step();
        for (int c = 0; c < 20; c++) begin
            if (out_fifo_valid === 1'b1 || out_valid === 1'b1) extra++;
            step();
        end
        n_checks++;
        if (extra !== 0) $display("FAIL midrst_extra: got %0d stray valid cycles expected 0", extra);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_pack_word();
        test_stream();
        test_backpressure();
        test_flush();
        test_unpack();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
